sram_bus_ctrl: RTL and testbench

Parametrised multicycle controller between the core's internal memory request port and the external asynchronous SRAM. It replaces the fixed, state-machine-driven CE/UB/LB/OE/WE strobing with a request/done handshake, configurable wait states and generic byte lanes. It owns the bidirectional SRAM data bus and guarantees no bus contention.

---
 rtl/sram_bus_ctrl.sv | 146 ++++++++++++++
 tb/tb_sram_bus_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_ctrl.sv
// ---------------------------------------------------------------------------
// sram_bus_ctrl : request/done controller for an asynchronous SRAM, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_bus_ctrl #(
    parameter  int ADDR_W      = 20,
    parameter  int DATA_W      = 16,
    parameter  int WAIT_CYCLES = 2,
    localparam int L           = DATA_W / 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [L-1:0]      be,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              CE_N,
    output logic              OE_N,
    output logic              WE_N,
    output logic [L-1:0]      BE_N,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Data
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              we_q;
    logic [L-1:0]      be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drive;
    logic [DATA_W-1:0] lane_mask;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < L; i++) begin
            lane_mask[8*i +: 8] = {8{be_q[i]}};
        end
    end

    // The bus is only ever driven while WE_N brackets the write, so it can
    // never overlap OE_N low.
    assign Data = drive ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            drive   <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
            rdata   <= '0;
            CE_N    <= 1'b1;
            OE_N    <= 1'b1;
            WE_N    <= 1'b1;
            BE_N    <= '1;
            ADDR    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        be_q    <= be;
                        wdata_q <= wdata;
                        ready   <= 1'b0;
                        if (be == '0) begin
                            // No lane selected: skip the SRAM cycle entirely.
                            done  <= 1'b1;
                            state <= S_DONE;
                            if (!we) begin
                                rdata <= '0;
                            end
                        end else begin
                            ADDR  <= addr;
                            CE_N  <= 1'b0;
                            BE_N  <= ~be;
                            state <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    cnt   <= CW'(WAIT_CYCLES);
                    state <= S_ACCESS;
                    if (we_q) begin
                        WE_N  <= 1'b0;
                        drive <= 1'b1;
                    end else begin
                        OE_N  <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    if (cnt == CW'(1)) begin
                        if (we_q) begin
                            WE_N  <= 1'b1;
                            state <= S_HOLD;
                        end else begin
                            rdata <= Data & lane_mask;
                            OE_N  <= 1'b1;
                            CE_N  <= 1'b1;
                            BE_N  <= '1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    drive <= 1'b0;
                    CE_N  <= 1'b1;
                    BE_N  <= '1;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_ctrl : scoreboard bench with SRAM models and a wait-state sweep
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_bus_ctrl;

    localparam int W = 2;

    logic Clk     = 1'b0;
    logic clk_run = 1'b0;
    logic Reset   = 1'b1;
    always begin
        #5;
        if (clk_run) Clk = ~Clk;
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic is_float(input logic [15:0] v);
        return (v === 16'hzzzz) || (v === 16'h0000);
    endfunction

    // ---------------- main DUT (W=2, 16-bit) ----------------
    logic        req = 1'b0, we = 1'b0;
    logic [19:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  be = '0;
    logic        ready, done, CE_N, OE_N, WE_N;
    logic [15:0] rdata;
    logic [1:0]  BE_N;
    logic [19:0] ADDR;
    wire  [15:0] Data;

    sram_bus_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(W)) u_dut (
        .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready), .done(done), .rdata(rdata), .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N),
        .BE_N(BE_N), .ADDR(ADDR), .Data(Data)
    );

    logic [15:0] mem [0:255];
    assign Data = (!CE_N && !OE_N) ? mem[ADDR[7:0]] : 16'hzzzz;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h23] = 16'hBEEF;
        mem[8'h40] = 16'h1100;
        mem[8'h77] = 16'h1234;
        mem[8'h88] = 16'hFFFF;
        mem[8'h99] = 16'h0F0F;
        forever begin
            @(posedge WE_N);
            if (CE_N === 1'b0) begin
                if (!BE_N[0]) mem[ADDR[7:0]][7:0]  = Data[7:0];
                if (!BE_N[1]) mem[ADDR[7:0]][15:8] = Data[15:8];
            end
        end
    end

    typedef struct {
        logic        is_rd;
        logic [15:0] rd;
        int          done_cyc;
        int          ce, oe, wen, drv;
    } exp_t;
    exp_t sb[$];

    int          m_ce, m_oe, m_we, m_drv, m_bad;
    logic [15:0] m_wdata = 16'h5C3A;
    logic [1:0]  m_ben   = 2'b11;
    logic [19:0] m_addr  = '0;
    logic        rdy_next = 1'b0;

    always @(negedge Clk) begin
        if (Reset) begin
            if (!CE_N) m_ce++;
            if (!OE_N) m_oe++;
            if (!WE_N) m_we++;
            if (Data === m_wdata) m_drv++;
            if (!CE_N && (BE_N !== m_ben || ADDR !== m_addr)) m_bad++;
            if (rdy_next) begin
                check_val("ready_after_done", 32'(ready), 32'd1);
                rdy_next = 1'b0;
            end
            if (done) begin
                check_val("ready_while_done", 32'(ready), 32'd0);
                if (sb.size() == 0) begin
                    check_val("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    if (e.is_rd) check_val("rdata", 32'(rdata), 32'(e.rd));
                    check_val("ce_low_cycles", 32'(m_ce), 32'(e.ce));
                    check_val("oe_low_cycles", 32'(m_oe), 32'(e.oe));
                    check_val("we_low_cycles", 32'(m_we), 32'(e.wen));
                    check_val("data_driven_cycles", 32'(m_drv), 32'(e.drv));
                    check_val("addr_be_stable", 32'(m_bad), 32'd0);
                    rdy_next = 1'b1;
                end
            end
        end
    end

    task automatic access(input logic w, input logic [19:0] a, input logic [15:0] d,
                          input logic [1:0] b, input logic [15:0] exp_rd);
        exp_t e;
        int   t;
        @(negedge Clk);
        for (int i = 0; i < 50 && !ready; i++) @(negedge Clk);
        if (!ready) check_val("ready_timeout", 32'(ready), 32'd1);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        m_ce = 0; m_oe = 0; m_we = 0; m_drv = 0; m_bad = 0;
        m_wdata = w ? d : 16'h5C3A;
        m_ben   = ~b;
        m_addr  = a;
        @(posedge Clk);
        #1;
        t = cyc;
        req = 1'b0;
        e.is_rd    = !w;
        e.rd       = exp_rd;
        e.done_cyc = (b == 2'b00) ? t : (w ? t + W + 2 : t + W + 1);
        e.ce       = (b == 2'b00) ? 0 : (w ? W + 2 : W + 1);
        e.oe       = (b != 2'b00 && !w) ? W : 0;
        e.wen      = (b != 2'b00 && w) ? W : 0;
        e.drv      = (b != 2'b00 && w) ? W + 1 : 0;
        sb.push_back(e);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge Clk);
        if (sb.size() != 0) begin
            check_val("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // ---------------- wait-state sweep (32-bit, req held high) ----------------
    logic sw_req = 1'b0;
    logic sw_on  = 1'b0;
    int   sw_t0  = 0;

    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int WW = (g == 0) ? 1 : 4;
        logic        rdy, dn, ce, oe, wen;
        logic [31:0] rd;
        logic [3:0]  ben;
        logic [19:0] ad;
        wire  [31:0] dq;
        int          nd   = 0;
        int          last = 0;

        assign dq = (!ce && !oe) ? (32'hDEAD0000 | 32'(WW)) : 32'hzzzzzzzz;

        sram_bus_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(WW)) u_sw (
            .Clk(Clk), .Reset(Reset), .req(sw_req), .we(1'b0), .addr(20'h00010),
            .wdata(32'h0), .be(4'hF), .ready(rdy), .done(dn), .rdata(rd), .CE_N(ce),
            .OE_N(oe), .WE_N(wen), .BE_N(ben), .ADDR(ad), .Data(dq)
        );

        always @(negedge Clk) begin
            if (Reset && sw_on && dn) begin
                check_val("sw_rdata", rd, 32'hDEAD0000 | 32'(WW));
                check_val("sw_addr", 32'(ad), 32'h10);
                check_val("sw_be_n_idle", 32'(ben), 32'hF);
                check_val("sw_we_n", 32'(wen), 32'd1);
                check_val("sw_ready_while_done", 32'(rdy), 32'd0);
                if (nd == 0) check_val("sw_first_latency", 32'(cyc), 32'(sw_t0 + WW + 2));
                else         check_val("sw_spacing", 32'(cyc - last), 32'(WW + 3));
                last = cyc;
                nd++;
            end
        end
    end

    // ---------------- sequence ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset with the clock stopped.
        #3 Reset = 1'b0;
        #1;
        check_val("rst_ce_n", 32'(CE_N), 32'd1);
        check_val("rst_oe_n", 32'(OE_N), 32'd1);
        check_val("rst_we_n", 32'(WE_N), 32'd1);
        check_val("rst_be_n", 32'(BE_N), 32'h3);
        check_val("rst_ready", 32'(ready), 32'd1);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_rdata", 32'(rdata), 32'd0);
        check_val("rst_addr", 32'(ADDR), 32'd0);
        check_val("rst_data_z", 32'(is_float(Data)), 32'd1);
        #6 Reset = 1'b1;
        clk_run = 1'b1;
        repeat (2) @(negedge Clk);

        access(1'b0, 20'h00123, 16'h0000, 2'b11, 16'hBEEF);
        access(1'b1, 20'h00040, 16'hA55A, 2'b01, 16'h0000);
        check_val("mem_partial_write", 32'(mem[8'h40]), 32'h115A);
        access(1'b0, 20'h00077, 16'h0000, 2'b10, 16'h1200);
        access(1'b0, 20'h00088, 16'h0000, 2'b00, 16'h0000);
        access(1'b1, 20'h00099, 16'h7E7E, 2'b00, 16'h0000);
        check_val("mem_be0_untouched", 32'(mem[8'h99]), 32'h0F0F);
        access(1'b1, 20'h00041, 16'hC3C3, 2'b11, 16'h0000);
        access(1'b0, 20'h00041, 16'h0000, 2'b11, 16'hC3C3);

        // Abort a write in ACCESS with reset, then resume normally.
        @(negedge Clk);
        req = 1'b1; we = 1'b1; addr = 20'h00050; wdata = 16'h3CC3; be = 2'b11;
        @(posedge Clk);
        #1 req = 1'b0;
        for (int i = 0; i < 10 && WE_N; i++) @(negedge Clk);
        check_val("abort_reached_access", 32'(WE_N), 32'd0);
        #2 Reset = 1'b0;
        #1;
        check_val("abort_we_n", 32'(WE_N), 32'd1);
        check_val("abort_ce_n", 32'(CE_N), 32'd1);
        check_val("abort_ready", 32'(ready), 32'd1);
        check_val("abort_data_z", 32'(Data === 16'h3CC3), 32'd0);
        repeat (2) begin
            @(negedge Clk);
            check_val("abort_no_done", 32'(done), 32'd0);
        end
        #1 Reset = 1'b1;
        access(1'b0, 20'h00123, 16'h0000, 2'b11, 16'hBEEF);

        // Sweep instances: continuous reads.
        @(negedge Clk);
        sw_on  = 1'b1;
        sw_t0  = cyc;
        sw_req = 1'b1;
        for (int i = 0; i < 100 && (g_sweep[0].nd < 4 || g_sweep[1].nd < 4); i++) @(negedge Clk);
        sw_req = 1'b0;
        check_val("sw_w1_count", 32'(g_sweep[0].nd >= 4), 32'd1);
        check_val("sw_w4_count", 32'(g_sweep[1].nd >= 4), 32'd1);
        repeat (10) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
